// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: per-PLL reset/lock/stability sequencing that produces a clean fabric reset.
// Optional lock-loss counter is built only when LOCK_SUPERVISOR_LOSS_COUNTER_EN is defined.
//
// state        | meaning
// RESET_PULSE  | pll_reset held high for RESET_PULSE_CYCLES
// WAIT_LOCK    | reset released, waiting for synced lock or timeout
// STABLE       | lock seen, counting consecutive locked cycles
// LOCKED       | lock stable, PLL contributes to all_locked
// FAILED       | retries exhausted, pll_reset held until clear_failed
module pll_lock_supervisor #(
  parameter int NUM_PLLS           = 2,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 125000,
  parameter int STABLE_CYCLES      = 1024,
  parameter int MAX_RETRIES        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PLLS-1:0] pll_lock,
  input  logic                clear_failed,
  output logic [NUM_PLLS-1:0] pll_reset,
  output logic                sys_rst_n,
  output logic                all_locked,
  output logic [NUM_PLLS-1:0] failed,
  output logic [7:0]          lock_loss_count
);

  localparam int MAX_TS  = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_TS > RESET_PULSE_CYCLES) ? MAX_TS : RESET_PULSE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PULSE,
    WAIT_LOCK,
    STABLE,
    LOCKED,
    FAILED
  } state_t;

  logic [NUM_PLLS-1:0] lock_meta;
  logic [NUM_PLLS-1:0] lock_s;
  logic [NUM_PLLS-1:0] locked_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta <= '0;
      lock_s    <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_pll
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [RW-1:0] retries, retries_next;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= RESET_PULSE;
        cnt     <= '0;
        retries <= '0;
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        retries <= retries_next;
      end
    end

    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      retries_next = retries;
      case (state)
        RESET_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          // The cycle that first sees lock counts as the first cycle of the stable window.
          if (lock_s[i]) begin
            state_next = STABLE;
            cnt_next   = CW'(1);
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retries == RETRY_LIMIT) begin
              state_next = FAILED;
            end else begin
              state_next   = RESET_PULSE;
              retries_next = retries + RW'(1);
            end
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s[i]) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt >= STABLE_LAST) begin
            state_next   = LOCKED;
            cnt_next     = '0;
            retries_next = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        LOCKED: begin
          if (!lock_s[i]) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        FAILED: begin
          if (clear_failed) begin
            state_next   = RESET_PULSE;
            cnt_next     = '0;
            retries_next = '0;
          end
        end
        default: begin
          state_next   = RESET_PULSE;
          cnt_next     = '0;
          retries_next = '0;
        end
      endcase
    end

    assign pll_reset[i]  = (state == RESET_PULSE) || (state == FAILED);
    assign failed[i]     = (state == FAILED);
    assign locked_vec[i] = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
      sys_rst_n  <= 1'b0;
    end else begin
      all_locked <= &locked_vec;
      sys_rst_n  <= all_locked && !(|failed);
    end
  end

`ifdef LOCK_SUPERVISOR_LOSS_COUNTER_EN
  logic [NUM_PLLS-1:0] loss;
  logic [3:0]          loss_pop;
  logic [8:0]          loss_sum;
  logic [7:0]          loss_cnt;

  assign loss = locked_vec & ~lock_s;

  always_comb begin
    loss_pop = '0;
    for (int k = 0; k < NUM_PLLS; k++) begin
      loss_pop = loss_pop + {3'b000, loss[k]};
    end
  end

  assign loss_sum = {1'b0, loss_cnt} + {5'b00000, loss_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else begin
      loss_cnt <= loss_sum[8] ? 8'hFF : loss_sum[7:0];
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = 8'h00;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with short timing parameters.
// Expected lock_loss_count follows LOCK_SUPERVISOR_LOSS_COUNTER_EN the same way the design does.
module tb_pll_lock_supervisor;

`ifdef LOCK_SUPERVISOR_LOSS_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pll_lock;
  logic       clear_failed;
  logic [1:0] pll_reset;
  logic       sys_rst_n;
  logic       all_locked;
  logic [1:0] failed;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .NUM_PLLS          (2),
    .RESET_PULSE_CYCLES(4),
    .TIMEOUT_CYCLES    (50),
    .STABLE_CYCLES     (8),
    .MAX_RETRIES       (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_lock       (pll_lock),
    .clear_failed   (clear_failed),
    .pll_reset      (pll_reset),
    .sys_rst_n      (sys_rst_n),
    .all_locked     (all_locked),
    .failed         (failed),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return CNT_EN ? ((v > 255) ? 32'd255 : 32'(v)) : 32'd0;
  endfunction

  initial begin
    rst_n        = 1'b0;
    pll_lock     = 2'b00;
    clear_failed = 1'b0;
    tick(3);
    check("rst_pll_reset", 32'(pll_reset), 32'h3);
    check("rst_sys_rst_n", 32'(sys_rst_n), 32'h0);
    check("rst_all_locked", 32'(all_locked), 32'h0);
    check("rst_failed", 32'(failed), 32'h0);
    check("rst_count", 32'(lock_loss_count), 32'h0);

    // Test 1: reset pulse length and lock-to-release latency
    rst_n = 1'b1;
    tick(3);
    check("t1_pulse_last", 32'(pll_reset), 32'h3);
    tick(1);
    check("t1_pulse_end", 32'(pll_reset), 32'h0);
    tick(9);
    pll_lock = 2'b11;
    tick(10);
    check("t1_not_yet_locked", 32'(all_locked), 32'h0);
    tick(1);
    check("t1_all_locked", 32'(all_locked), 32'h1);
    check("t1_sys_rst_low", 32'(sys_rst_n), 32'h0);
    tick(1);
    check("t1_sys_rst_high", 32'(sys_rst_n), 32'h1);

    // Test 2: 3-cycle glitch on PLL0 while locked
    pll_lock = 2'b10;
    tick(3);
    check("t2_loss_count", 32'(lock_loss_count), exp_cnt(1));
    pll_lock = 2'b11;
    tick(1);
    check("t2_all_locked_drop", 32'(all_locked), 32'h0);
    tick(1);
    check("t2_sys_rst_drop", 32'(sys_rst_n), 32'h0);
    tick(8);
    check("t2_relock_early", 32'(all_locked), 32'h0);
    tick(1);
    check("t2_relock_all", 32'(all_locked), 32'h1);
    tick(1);
    check("t2_relock_sys", 32'(sys_rst_n), 32'h1);

    // Test 3: PLL1 never locks -> three pulses, three timeouts, FAILED
    rst_n    = 1'b0;
    pll_lock = 2'b01;
    tick(2);
    check("t3_rst_count", 32'(lock_loss_count), 32'h0);
    rst_n = 1'b1;
    tick(3);
    check("t3_p1_high", 32'(pll_reset[1]), 32'h1);
    tick(1);
    check("t3_p1_low", 32'(pll_reset[1]), 32'h0);
    tick(49);
    check("t3_w1_end", 32'(pll_reset[1]), 32'h0);
    tick(1);
    check("t3_p2_start", 32'(pll_reset[1]), 32'h1);
    tick(3);
    check("t3_p2_high", 32'(pll_reset[1]), 32'h1);
    tick(1);
    check("t3_p2_low", 32'(pll_reset[1]), 32'h0);
    tick(49);
    check("t3_w2_end", 32'(pll_reset[1]), 32'h0);
    tick(1);
    check("t3_p3_start", 32'(pll_reset[1]), 32'h1);
    tick(3);
    check("t3_p3_high", 32'(pll_reset[1]), 32'h1);
    tick(1);
    check("t3_p3_low", 32'(pll_reset[1]), 32'h0);
    tick(49);
    check("t3_not_failed_yet", 32'(failed), 32'h0);
    tick(1);
    check("t3_failed", 32'(failed), 32'h2);
    check("t3_pll_reset", 32'(pll_reset), 32'h2);
    tick(20);
    check("t3_failed_held", 32'(failed), 32'h2);
    check("t3_reset_held", 32'(pll_reset), 32'h2);
    check("t3_sys_rst_low", 32'(sys_rst_n), 32'h0);
    check("t3_all_locked_low", 32'(all_locked), 32'h0);

    // Test 4: clear_failed with lock now present
    pll_lock = 2'b11;
    tick(5);
    clear_failed = 1'b1;
    tick(1);
    clear_failed = 1'b0;
    check("t4_failed_clear", 32'(failed), 32'h0);
    check("t4_pulse_start", 32'(pll_reset), 32'h2);
    tick(3);
    check("t4_pulse_high", 32'(pll_reset), 32'h2);
    tick(1);
    check("t4_pulse_low", 32'(pll_reset), 32'h0);
    tick(8);
    check("t4_not_yet_locked", 32'(all_locked), 32'h0);
    tick(1);
    check("t4_all_locked", 32'(all_locked), 32'h1);
    tick(1);
    check("t4_sys_rst_high", 32'(sys_rst_n), 32'h1);
    clear_failed = 1'b1;
    tick(1);
    clear_failed = 1'b0;
    tick(2);
    check("t4_clear_noeffect_lock", 32'(all_locked), 32'h1);
    check("t4_clear_noeffect_rst", 32'(pll_reset), 32'h0);

    // Test 5: simultaneous double loss, repeated past saturation
    for (int k = 1; k <= 130; k++) begin
      pll_lock = 2'b00;
      tick(3);
      check("t5_count", 32'(lock_loss_count), exp_cnt(2 * k));
      pll_lock = 2'b11;
      tick(12);
    end
    check("t5_final_locked", 32'(all_locked), 32'h1);

    // Test 6: reset in the middle of the stable window
    pll_lock = 2'b00;
    tick(4);
    pll_lock = 2'b11;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check("t6_pll_reset", 32'(pll_reset), 32'h3);
    check("t6_sys_rst_n", 32'(sys_rst_n), 32'h0);
    check("t6_count", 32'(lock_loss_count), 32'h0);
    check("t6_failed", 32'(failed), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
